// File: rtl/gpu_frame_reader.sv
// Display-side frame scanner: fetches words over the CPU GPU read port and
// streams them out as four 8-bit pixels each, LSB byte first.
module gpu_frame_reader #(
    parameter logic [31:0] BASE_ADDR = 32'd0,
    parameter int unsigned NUM_WORDS = 16384,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        src_sel,
    output logic [31:0] gpu_addr,
    input  logic [31:0] ram_data,
    input  logic [31:0] rom_data,
    output logic [7:0]  pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_last,
    output logic        busy,
    output logic        done
);

    localparam int unsigned IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int unsigned WW = $clog2(RD_LAT + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_WORDS - 1);
    localparam logic [WW-1:0] WAIT_END = WW'(RD_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_UNPACK,
        S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [1:0]    k_q, k_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [31:0]   word_q, word_d;
    logic [31:0]   addr_q, addr_d;
    logic          src_q, src_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            k_q     <= '0;
            wait_q  <= '0;
            word_q  <= '0;
            addr_q  <= '0;
            src_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            k_q     <= k_d;
            wait_q  <= wait_d;
            word_q  <= word_d;
            addr_q  <= addr_d;
            src_q   <= src_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        k_d     = k_q;
        wait_d  = wait_q;
        word_d  = word_q;
        addr_d  = addr_q;
        src_d   = src_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_d   = src_sel;
                    idx_d   = '0;
                    addr_d  = BASE_ADDR;
                    wait_d  = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Address has been held RD_LAT cycles once wait hits its end.
                if (wait_q == WAIT_END) begin
                    word_d  = src_q ? rom_data : ram_data;
                    k_d     = 2'd0;
                    state_d = S_UNPACK;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_UNPACK: begin
                if (pix_ready) begin
                    if (k_q != 2'd3) begin
                        k_d = k_q + 2'd1;
                    end else if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        addr_d  = BASE_ADDR + 32'(idx_q) + 32'd1;
                        wait_d  = '0;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign gpu_addr  = addr_q;
    assign pix_valid = (state_q == S_UNPACK);
    assign pix_data  = word_q[8*k_q +: 8];
    assign pix_last  = pix_valid && (idx_q == LAST_IDX) && (k_q == 2'd3);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);

endmodule
